return_coin_dispenser: RTL
==========================

RETURN_COIN_DISPENSER -- requirements
Module: return_coin_dispenser

Interface
REQ-001 Parameter kNumCoins, default 3, number of coin denominations, index 0 smallest.
REQ-002 Parameter kTotalBits, default 31, width of all balance quantities.
REQ-003 Parameter kCoinValue0/1/2, default 100/500/1000, denomination values, strictly ascending.
REQ-004 Parameter kInitCount, default 8, per-denomination coin count loaded on reset and refill.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 i_trigger_return  input  1  single-cycle request to return the balance on i_total.
REQ-008 i_total  input  kTotalBits  balance to return; sampled only on an accepted trigger.
REQ-009 i_refill  input  1  reloads every coin count to kInitCount.
REQ-010 o_return_coin  output  kNumCoins  registered; at most one bit set per cycle, one coin ejected.
REQ-011 o_busy  output  1  high while not in IDLE.
REQ-012 o_done  output  1  one-cycle pulse when a return completes.
REQ-013 o_residue  output  kTotalBits  undispensable remainder; valid while o_done is high, otherwise 0.
REQ-014 o_coin_count  output  kNumCoins*8  packed per-denomination stock, 8 bits each, coin i at bits [8i+7:8i].

Function
REQ-015 FSM states: IDLE, DISPENSE, DONE.
REQ-016 IDLE with i_trigger_return=1: latch i_total into remaining; next state DISPENSE if i_total>0, else DONE.
REQ-017 Trigger in DISPENSE or DONE: ignored; i_total is not resampled.
REQ-018 DISPENSE, each cycle: select the largest i with kCoinValue_i <= remaining and count_i > 0.
REQ-019 When a coin is selected: next-cycle o_return_coin = one-hot(i), remaining -= kCoinValue_i, count_i -= 1.
REQ-020 No coin selectable: o_return_coin = 0, next state DONE.
REQ-021 Exactly one coin per DISPENSE cycle; first coin appears 2 cycles after the trigger cycle.
REQ-022 DONE lasts exactly 1 cycle: o_done=1, o_residue=remaining, o_return_coin=0; then IDLE.
REQ-023 Subtraction at kTotalBits width; remaining never underflows, guaranteed by the <= check.
REQ-024 Counts saturate at 0, never wrap; an empty denomination is skipped and smaller coins are used.
REQ-025 i_refill is honoured only in IDLE; ignored in DISPENSE and DONE.
REQ-026 i_refill and i_trigger_return together in IDLE: both take effect; dispensing uses the refilled counts.

Reset
REQ-027 Reset forces state=IDLE, remaining=0, o_return_coin=0, o_busy=0, o_done=0, o_residue=0.
REQ-028 Reset sets every count to kInitCount.
REQ-029 Reset mid-DISPENSE aborts the return: no o_done pulse, and the residual balance is discarded.
REQ-030 Reset has priority over every other input.

Structure
REQ-031 kNumCoins, kTotalBits, the coin values and the state encodings SHALL live in the shared vending-machine definitions file, next to kNumItems.
REQ-032 One sub-module, coin_selector: combinational largest-eligible-coin picker (remaining, counts -> one-hot, valid).
REQ-033 o_return_coin uses the same bit-to-denomination mapping as the machine's coin input vector.

Verification
REQ-034 Trigger with i_total=1600, full stock -> coins 1000, 500, 100 on consecutive cycles; then o_done with o_residue=0.
REQ-035 Trigger with i_total=150 -> coin 100 only; o_done with o_residue=50; count0 drops from 8 to 7.
REQ-036 Stock 1000 reduced to 1, i_total=2000 -> coins 1000, 500, 500; o_done with o_residue=0; count2 ends at 0.
REQ-037 Trigger with i_total=0 -> no coin; o_done 1 cycle after the trigger, o_residue=0.
REQ-038 Second trigger (i_total=500) during a 2700 return -> ignored; sequence 1000, 1000, 500, 100, 100 unchanged.
REQ-039 Reset asserted after the first coin of a 1600 return -> o_return_coin=0 and IDLE next cycle; no o_done; counts back to 8.

Source files
------------

// File: rtl/return_coin_dispenser_pkg.sv
// Shared vending-machine definitions: coin denominations, balance width and
// the return-dispenser state encoding.
package return_coin_dispenser_pkg;

    localparam int unsigned kNumItems   = 4;
    localparam int unsigned kNumCoins   = 3;
    localparam int unsigned kTotalBits  = 31;
    localparam int unsigned kCountBits  = 8;
    localparam int unsigned kInitCount  = 8;

    // Coin input vector and return vector share this bit order: bit 0 = smallest coin.
    localparam int unsigned kCoinValue0 = 100;
    localparam int unsigned kCoinValue1 = 500;
    localparam int unsigned kCoinValue2 = 1000;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDispense = 2'd1,
        StDone     = 2'd2
    } dispense_state_e;

    function automatic int unsigned coin_value(input int unsigned idx,
                                               input int unsigned v0,
                                               input int unsigned v1,
                                               input int unsigned v2);
        int unsigned v;
        unique case (idx)
            0:       v = v0;
            1:       v = v1;
            default: v = v2;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/return_coin_dispenser_coin_selector.sv
// Combinational picker: the largest denomination that fits the remaining
// balance and still has stock. Reports it one-hot with its value.
module coin_selector
    import return_coin_dispenser_pkg::*;
#(
    parameter int unsigned NumCoins  = kNumCoins,
    parameter int unsigned TotalBits = kTotalBits,
    parameter int unsigned CountBits = kCountBits
) (
    input  logic [TotalBits-1:0]          remaining_i,
    input  logic [NumCoins*TotalBits-1:0] coin_values_i,
    input  logic [NumCoins*CountBits-1:0] counts_i,
    output logic [NumCoins-1:0]           sel_onehot_o,
    output logic [TotalBits-1:0]          sel_value_o,
    output logic                          sel_valid_o
);

    logic [TotalBits-1:0] value;
    logic [CountBits-1:0] count;

    // Ascending scan: the last eligible index wins, i.e. the largest coin.
    always_comb begin
        sel_onehot_o = '0;
        sel_value_o  = '0;
        sel_valid_o  = 1'b0;
        value        = '0;
        count        = '0;
        for (int i = 0; i < int'(NumCoins); i++) begin
            value = coin_values_i[i*TotalBits +: TotalBits];
            count = counts_i[i*CountBits +: CountBits];
            if ((value <= remaining_i) && (count != '0)) begin
                sel_onehot_o    = '0;
                sel_onehot_o[i] = 1'b1;
                sel_value_o     = value;
                sel_valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/return_coin_dispenser.sv
// Change-return dispenser: on a trigger, ejects one coin per cycle, largest
// first, then pulses o_done with whatever balance could not be paid out.
module return_coin_dispenser #(
    parameter int unsigned kNumCoins   = return_coin_dispenser_pkg::kNumCoins,
    parameter int unsigned kTotalBits  = return_coin_dispenser_pkg::kTotalBits,
    parameter int unsigned kCoinValue0 = return_coin_dispenser_pkg::kCoinValue0,
    parameter int unsigned kCoinValue1 = return_coin_dispenser_pkg::kCoinValue1,
    parameter int unsigned kCoinValue2 = return_coin_dispenser_pkg::kCoinValue2,
    parameter int unsigned kInitCount  = return_coin_dispenser_pkg::kInitCount
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_trigger_return,
    input  logic [kTotalBits-1:0]   i_total,
    input  logic                    i_refill,
    output logic [kNumCoins-1:0]    o_return_coin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [kTotalBits-1:0]   o_residue,
    output logic [kNumCoins*8-1:0]  o_coin_count
);
    import return_coin_dispenser_pkg::*;

    localparam logic [7:0] kInitCnt = 8'(kInitCount);

    dispense_state_e       state_q, state_d;
    logic [kTotalBits-1:0] remaining_q, remaining_d;
    logic [7:0]            count_q [kNumCoins];
    logic [7:0]            count_d [kNumCoins];
    logic [kNumCoins-1:0]  return_coin_q, return_coin_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [kTotalBits-1:0] residue_q, residue_d;

    logic [kNumCoins*kTotalBits-1:0] coin_values;
    logic [kNumCoins*8-1:0]          counts_flat;
    logic [kNumCoins-1:0]            sel_onehot;
    logic [kTotalBits-1:0]           sel_value;
    logic                            sel_valid;

    for (genvar g = 0; g < int'(kNumCoins); g++) begin : g_coin
        assign coin_values[g*kTotalBits +: kTotalBits] =
            kTotalBits'(coin_value(g, kCoinValue0, kCoinValue1, kCoinValue2));
        assign counts_flat[g*8 +: 8] = count_q[g];
    end

    coin_selector #(
        .NumCoins  (kNumCoins),
        .TotalBits (kTotalBits),
        .CountBits (8)
    ) u_coin_selector (
        .remaining_i   (remaining_q),
        .coin_values_i (coin_values),
        .counts_i      (counts_flat),
        .sel_onehot_o  (sel_onehot),
        .sel_value_o   (sel_value),
        .sel_valid_o   (sel_valid)
    );

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        count_d       = count_q;
        return_coin_d = '0;

        unique case (state_q)
            StIdle: begin
                if (i_refill) begin
                    for (int i = 0; i < int'(kNumCoins); i++) begin
                        count_d[i] = kInitCnt;
                    end
                end
                if (i_trigger_return) begin
                    remaining_d = i_total;
                    state_d     = (i_total != '0) ? StDispense : StDone;
                end
            end
            StDispense: begin
                if (sel_valid) begin
                    return_coin_d = sel_onehot;
                    remaining_d   = remaining_q - sel_value;
                    for (int i = 0; i < int'(kNumCoins); i++) begin
                        if (sel_onehot[i] && (count_q[i] != 8'd0)) begin
                            count_d[i] = count_q[i] - 8'd1;
                        end
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered alongside the state they describe.
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        residue_d = (state_d == StDone) ? remaining_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            remaining_q   <= '0;
            return_coin_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            residue_q     <= '0;
            for (int i = 0; i < int'(kNumCoins); i++) begin
                count_q[i] <= kInitCnt;
            end
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            return_coin_q <= return_coin_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            residue_q     <= residue_d;
            count_q       <= count_d;
        end
    end

    assign o_return_coin = return_coin_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_residue     = residue_q;
    assign o_coin_count  = counts_flat;

endmodule
